i2c_cfg_seq: RTL

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

---
 rtl/i2c_cfg_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i2c_cfg_seq.sv
// Walks a register table, issuing one I2C write per entry after a power-up wait.
// Entries whose address is 16'hFFFF are timed pauses of wr_data*DELAY_UNIT clocks.
module i2c_cfg_seq #(
    parameter logic [7:0]  REG_NUM      = 8'd251,
    parameter logic [14:0] CNT_WAIT_MAX = 15'd20000,
    parameter logic [15:0] TIMEOUT_MAX  = 16'd4000,
    parameter logic [9:0]  DELAY_UNIT   = 10'd1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cfg_restart,
    input  logic        i2c_end,
    input  logic [23:0] cfg_word,
    output logic [7:0]  cfg_idx,
    output logic        i2c_start,
    output logic        wr_en,
    output logic        rd_en,
    output logic        addr_num,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        WAIT_PWR,
        FETCH,
        ISSUE,
        WAIT_END,
        DELAY,
        NEXT,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [14:0] cnt_wait;
    logic [15:0] cnt_timeout;
    logic [17:0] cnt_delay;
    logic [17:0] delay_len;
    logic        wait_last;
    logic        timeout_last;
    logic        delay_last;
    logic        last_entry;

    assign wr_en    = 1'b1;
    assign rd_en    = 1'b0;
    assign addr_num = 1'b1;
    assign busy     = (state != DONE);

    // 8-bit count times 10-bit unit always fits in 18 bits
    assign delay_len    = 18'(wr_data) * 18'(DELAY_UNIT);
    assign wait_last    = (cnt_wait == CNT_WAIT_MAX - 15'd1);
    assign timeout_last = (cnt_timeout == TIMEOUT_MAX - 16'd1);
    assign delay_last   = (delay_len == 18'd0) || (cnt_delay == delay_len - 18'd1);
    assign last_entry   = (cfg_idx == REG_NUM - 8'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= WAIT_PWR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_PWR: if (wait_last) next_state = FETCH;
            FETCH:    next_state = (cfg_word[23:8] == 16'hFFFF) ? DELAY : ISSUE;
            ISSUE:    next_state = WAIT_END;
            WAIT_END: if (i2c_end || timeout_last) next_state = NEXT;
            DELAY:    if (delay_last) next_state = NEXT;
            NEXT:     next_state = last_entry ? DONE : FETCH;
            DONE:     if (cfg_restart) next_state = FETCH;
            default:  next_state = WAIT_PWR;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_wait    <= '0;
            cnt_timeout <= '0;
            cnt_delay   <= '0;
            cfg_idx     <= '0;
            i2c_start   <= 1'b0;
            byte_addr   <= '0;
            wr_data     <= '0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            i2c_start <= (next_state == ISSUE);
            case (state)
                WAIT_PWR: if (!wait_last) cnt_wait <= cnt_wait + 15'd1;
                FETCH: begin
                    byte_addr   <= cfg_word[23:8];
                    wr_data     <= cfg_word[7:0];
                    cnt_timeout <= '0;
                    cnt_delay   <= '0;
                end
                // A completion arriving on the timeout terminal still counts as success
                WAIT_END: begin
                    if (!i2c_end) begin
                        if (timeout_last)
                            cfg_err <= 1'b1;
                        else
                            cnt_timeout <= cnt_timeout + 16'd1;
                    end
                end
                DELAY: if (!delay_last) cnt_delay <= cnt_delay + 18'd1;
                NEXT: begin
                    if (last_entry)
                        cfg_done <= 1'b1;
                    else
                        cfg_idx <= cfg_idx + 8'd1;
                end
                DONE: begin
                    if (cfg_restart) begin
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                        cfg_idx  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
